// File: rtl/victim_cache_param_if.sv
// L2 <-> victim cache <-> pmem signal bundle.
// slave = victim cache view, master = L2/pmem environment view.
interface victim_cache_param_if #(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128
);
   logic              l2_read;
   logic              l2_write;
   logic [ADDR_W-1:0] l2_address;
   logic              l2_victim_valid;
   logic [ADDR_W-1:0] l2_victim_addr;
   logic [LINE_W-1:0] l2_wdata;
   logic              l2_victim_dirty;
   logic              l2_resp;
   logic [LINE_W-1:0] l2_rdata;
   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   logic [LINE_W-1:0] pmem_wdata;
   logic [LINE_W-1:0] pmem_rdata;
   logic              pmem_resp;

   modport slave (
      input  l2_read, l2_write, l2_address, l2_victim_valid, l2_victim_addr,
             l2_wdata, l2_victim_dirty, pmem_rdata, pmem_resp,
      output l2_resp, l2_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
   );

   modport master (
      output l2_read, l2_write, l2_address, l2_victim_valid, l2_victim_addr,
             l2_wdata, l2_victim_dirty, pmem_rdata, pmem_resp,
      input  l2_resp, l2_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
   );
endinterface

// File: rtl/victim_cache_param.sv
// Fully-associative victim cache between L2 and pmem with true-LRU replacement.
// Define VC_STATS_EN to add saturating hit/miss/write-back counters.
module victim_cache_param #(
   parameter int ENTRIES  = 4,
   parameter int ADDR_W   = 16,
   parameter int LINE_W   = 128,
   parameter int OFFSET_W = 4
) (
   input  logic        clk,
   input  logic        rst_n,
`ifdef VC_STATS_EN
   output logic [31:0] hit_count,
   output logic [31:0] miss_count,
   output logic [31:0] wb_count,
`endif
   victim_cache_param_if.slave bus
);
   localparam int TAG_W = ADDR_W - OFFSET_W;
   localparam int IDX_W = $clog2(ENTRIES);

   typedef logic [ENTRIES-1:0][IDX_W-1:0] age_t;
   typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_FETCH, S_RESP} state_e;

   state_e                         state_q, state_d;
   logic [ENTRIES-1:0]             valid_q, valid_d, dirty_q, dirty_d;
   age_t                           age_q, age_d;
   logic [ENTRIES-1:0][TAG_W-1:0]  tag_q, tag_d;
   logic [ENTRIES-1:0][LINE_W-1:0] line_q, line_d;
   logic                           req_wr_q, req_wr_d, vic_vld_q, vic_vld_d;
   logic                           vic_dirty_q, vic_dirty_d;
   logic [TAG_W-1:0]               req_tag_q, req_tag_d, vic_tag_q, vic_tag_d;
   logic [LINE_W-1:0]              vic_data_q, vic_data_d, rdata_q, rdata_d;
   logic [IDX_W-1:0]               slot_q, slot_d;

   logic             hit, need_wb, alias_hit, ins_en, ins_keep;
   logic [IDX_W-1:0] hit_idx, repl_idx, ins_idx;
   logic             unused_offsets;

   assign unused_offsets = ^{bus.l2_address[OFFSET_W-1:0], bus.l2_victim_addr[OFFSET_W-1:0]};

   // Touched slot becomes youngest; everything younger than it ages by one.
   function automatic age_t age_touch(input age_t a, input logic [IDX_W-1:0] s);
      age_t r;
      r = a;
      for (int i = 0; i < ENTRIES; i++)
         if (a[i] < a[s]) r[i] = a[i] + IDX_W'(1);
      r[s] = '0;
      return r;
   endfunction

   function automatic age_t age_inval(input age_t a, input logic [IDX_W-1:0] s);
      age_t r;
      r = a;
      for (int i = 0; i < ENTRIES; i++)
         if (a[i] > a[s]) r[i] = a[i] - IDX_W'(1);
      r[s] = IDX_W'(ENTRIES-1);
      return r;
   endfunction

   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      repl_idx = '0;
      for (int i = ENTRIES-1; i >= 0; i--)
         if (valid_q[i] && tag_q[i] == req_tag_q) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      for (int i = 0; i < ENTRIES; i++)
         if (age_q[i] == IDX_W'(ENTRIES-1)) repl_idx = IDX_W'(i);
      // descending scan so the lowest-index invalid slot wins over LRU
      for (int i = ENTRIES-1; i >= 0; i--)
         if (!valid_q[i]) repl_idx = IDX_W'(i);
   end

   assign need_wb   = valid_q[repl_idx] & dirty_q[repl_idx];
   assign alias_hit = ~req_wr_q & vic_vld_q & (vic_tag_q == req_tag_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (bus.l2_read || bus.l2_write) state_d = S_LOOKUP;
         S_LOOKUP:
            if (req_wr_q)                state_d = (!hit && need_wb) ? S_WB : S_RESP;
            else if (alias_hit || hit)   state_d = S_RESP;
            else if (vic_vld_q && need_wb) state_d = S_WB;
            else                         state_d = S_FETCH;
         S_WB:     if (bus.pmem_resp) state_d = req_wr_q ? S_RESP : S_FETCH;
         S_FETCH:  if (bus.pmem_resp) state_d = S_RESP;
         S_RESP:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.l2_resp      = (state_q == S_RESP);
      bus.pmem_read    = 1'b0;
      bus.pmem_write   = 1'b0;
      bus.pmem_address = '0;
      bus.pmem_wdata   = '0;
      case (state_q)
         S_WB: begin
            bus.pmem_write   = 1'b1;
            bus.pmem_address = {tag_q[slot_q], {OFFSET_W{1'b0}}};
            bus.pmem_wdata   = line_q[slot_q];
         end
         S_FETCH: begin
            bus.pmem_read    = 1'b1;
            bus.pmem_address = {req_tag_q, {OFFSET_W{1'b0}}};
         end
         default: ;
      endcase
   end

   assign bus.l2_rdata = rdata_q;

   // Every VC allocation (swap, insert, write update) funnels through ins_*.
   always_comb begin
      valid_d     = valid_q;
      dirty_d     = dirty_q;
      age_d       = age_q;
      tag_d       = tag_q;
      line_d      = line_q;
      req_wr_d    = req_wr_q;
      req_tag_d   = req_tag_q;
      vic_vld_d   = vic_vld_q;
      vic_tag_d   = vic_tag_q;
      vic_data_d  = vic_data_q;
      vic_dirty_d = vic_dirty_q;
      rdata_d     = rdata_q;
      slot_d      = slot_q;
      ins_en      = 1'b0;
      ins_keep    = 1'b0;
      ins_idx     = repl_idx;
      case (state_q)
         S_IDLE: if (bus.l2_read || bus.l2_write) begin
            req_wr_d    = bus.l2_write;
            req_tag_d   = bus.l2_address[ADDR_W-1:OFFSET_W];
            vic_vld_d   = bus.l2_write | bus.l2_victim_valid;
            vic_tag_d   = bus.l2_write ? bus.l2_address[ADDR_W-1:OFFSET_W]
                                       : bus.l2_victim_addr[ADDR_W-1:OFFSET_W];
            vic_data_d  = bus.l2_wdata;
            vic_dirty_d = bus.l2_victim_dirty;
         end
         S_LOOKUP: begin
            slot_d = repl_idx;
            if (req_wr_q) begin
               if (hit) begin
                  ins_en   = 1'b1;
                  ins_idx  = hit_idx;
                  ins_keep = 1'b1;
               end else begin
                  ins_en = ~need_wb;
               end
            end else if (alias_hit) begin
               rdata_d = vic_data_q;
               if (hit) begin
                  ins_en  = 1'b1;
                  ins_idx = hit_idx;
               end
            end else if (hit) begin
               rdata_d = line_q[hit_idx];
               if (vic_vld_q) begin
                  ins_en  = 1'b1;
                  ins_idx = hit_idx;
               end else begin
                  valid_d[hit_idx] = 1'b0;
                  dirty_d[hit_idx] = 1'b0;
                  age_d            = age_inval(age_q, hit_idx);
               end
            end else if (vic_vld_q) begin
               ins_en = ~need_wb;
            end
         end
         S_WB: if (bus.pmem_resp) begin
            ins_en  = 1'b1;
            ins_idx = slot_q;
         end
         S_FETCH: if (bus.pmem_resp) rdata_d = bus.pmem_rdata;
         default: ;
      endcase
      if (ins_en) begin
         tag_d[ins_idx]   = vic_tag_q;
         line_d[ins_idx]  = vic_data_q;
         valid_d[ins_idx] = 1'b1;
         dirty_d[ins_idx] = vic_dirty_q | (ins_keep & dirty_q[ins_idx]);
         age_d            = age_touch(age_q, ins_idx);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q     <= '0;
         dirty_q     <= '0;
         for (int i = 0; i < ENTRIES; i++) age_q[i] <= IDX_W'(i);
         tag_q       <= '0;
         line_q      <= '0;
         req_wr_q    <= 1'b0;
         req_tag_q   <= '0;
         vic_vld_q   <= 1'b0;
         vic_tag_q   <= '0;
         vic_data_q  <= '0;
         vic_dirty_q <= 1'b0;
         rdata_q     <= '0;
         slot_q      <= '0;
      end else begin
         valid_q     <= valid_d;
         dirty_q     <= dirty_d;
         age_q       <= age_d;
         tag_q       <= tag_d;
         line_q      <= line_d;
         req_wr_q    <= req_wr_d;
         req_tag_q   <= req_tag_d;
         vic_vld_q   <= vic_vld_d;
         vic_tag_q   <= vic_tag_d;
         vic_data_q  <= vic_data_d;
         vic_dirty_q <= vic_dirty_d;
         rdata_q     <= rdata_d;
         slot_q      <= slot_d;
      end
   end

`ifdef VC_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, wb_cnt_q, wb_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      wb_cnt_d   = wb_cnt_q;
      if (state_q == S_LOOKUP && !req_wr_q) begin
         if (alias_hit || hit) hit_cnt_d  = hit_cnt_q + {31'b0, hit_cnt_q != '1};
         else                  miss_cnt_d = miss_cnt_q + {31'b0, miss_cnt_q != '1};
      end
      if (state_q == S_WB && bus.pmem_resp)
         wb_cnt_d = wb_cnt_q + {31'b0, wb_cnt_q != '1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         wb_cnt_q   <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
         wb_cnt_q   <= wb_cnt_d;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
   assign wb_count   = wb_cnt_q;
`endif
endmodule

// File: tb/tb_victim_cache_param.sv
// Directed bench for victim_cache_param; pmem answers one cycle after each request.
// Build with VC_STATS_EN defined to include the counter scenario.
module tb_victim_cache_param;
   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   victim_cache_param_if #(.ADDR_W(16), .LINE_W(128)) bus ();

`ifdef VC_STATS_EN
   logic [31:0] hit_count, miss_count, wb_count;
`endif

   victim_cache_param #(.ENTRIES(4), .ADDR_W(16), .LINE_W(128), .OFFSET_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef VC_STATS_EN
      .hit_count (hit_count),
      .miss_count(miss_count),
      .wb_count  (wb_count),
`endif
      .bus       (bus)
   );

   // results of the last request
   int           r_cyc, r_nrd, r_nwr;
   logic [127:0] r_rdata, r_wr_data;
   logic [15:0]  r_rd_addr, r_wr_addr;
   logic         r_resp2;

   function automatic logic [127:0] pat(input logic [15:0] a);
      return {8{a}};
   endfunction

   task automatic clear_inputs();
      bus.l2_read = 0; bus.l2_write = 0; bus.l2_address = '0;
      bus.l2_victim_valid = 0; bus.l2_victim_addr = '0; bus.l2_wdata = '0;
      bus.l2_victim_dirty = 0; bus.pmem_rdata = '0; bus.pmem_resp = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask

   // Cycle 0 is the edge where IDLE first sees the request.
   task automatic do_req(input bit wr, input logic [15:0] addr, input bit vv,
                         input logic [15:0] vaddr, input logic [127:0] wdata,
                         input bit vd, input logic [127:0] pdata);
      @(negedge clk);
      bus.l2_read = !wr; bus.l2_write = wr; bus.l2_address = addr;
      bus.l2_victim_valid = vv; bus.l2_victim_addr = vaddr;
      bus.l2_wdata = wdata; bus.l2_victim_dirty = vd;
      r_cyc = -1; r_nrd = 0; r_nwr = 0; r_rdata = 'x;
      r_rd_addr = 'x; r_wr_addr = 'x; r_wr_data = 'x;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         bus.pmem_resp = 0;
         if (bus.l2_resp) begin
            r_cyc = c;
            r_rdata = bus.l2_rdata;
            break;
         end
         if (bus.pmem_read) begin
            r_nrd++; r_rd_addr = bus.pmem_address;
            bus.pmem_rdata = pdata; bus.pmem_resp = 1;
         end else if (bus.pmem_write) begin
            r_nwr++; r_wr_addr = bus.pmem_address; r_wr_data = bus.pmem_wdata;
            bus.pmem_resp = 1;
         end
      end
      bus.l2_read = 0; bus.l2_write = 0; bus.l2_victim_valid = 0; bus.pmem_resp = 0;
      @(negedge clk);
      r_resp2 = bus.l2_resp;
   endtask

   task automatic test_reset();
      rst_n = 0;
      clear_inputs();
      repeat (2) @(negedge clk);
      tests++; if ({bus.l2_resp, bus.pmem_read, bus.pmem_write} !== 3'b000) begin
         fails++; $display("FAIL reset_ctrl: got %b want 000", {bus.l2_resp, bus.pmem_read, bus.pmem_write}); end
      tests++; if (bus.pmem_address !== 16'h0) begin
         fails++; $display("FAIL reset_paddr: got %h want 0", bus.pmem_address); end
      tests++; if (bus.l2_rdata !== 128'h0 || bus.pmem_wdata !== 128'h0) begin
         fails++; $display("FAIL reset_data: got %h/%h want 0", bus.l2_rdata, bus.pmem_wdata); end
      rst_n = 1;
      repeat (2) @(negedge clk);
      tests++; if (bus.l2_resp !== 1'b0) begin
         fails++; $display("FAIL reset_idle_resp: got %b want 0", bus.l2_resp); end
   endtask

   task automatic test_miss_fetch();
      do_reset();
      do_req(0, 16'h1230, 0, 16'h0, '0, 0, pat(16'h1230));
      tests++; if (r_nrd !== 1 || r_rd_addr !== 16'h1230) begin
         fails++; $display("FAIL t1_fetch: got %0d reads addr %h want 1 addr 1230", r_nrd, r_rd_addr); end
      tests++; if (r_cyc !== 3 || r_rdata !== pat(16'h1230)) begin
         fails++; $display("FAIL t1_data: got cyc %0d data %h want 3 %h", r_cyc, r_rdata, pat(16'h1230)); end
      tests++; if (r_resp2 !== 1'b0 || r_nwr !== 0) begin
         fails++; $display("FAIL t1_resp_pulse: got resp2 %b writes %0d want 0 0", r_resp2, r_nwr); end
      // unaligned re-read must fetch again at the aligned address
      do_req(0, 16'h1237, 0, 16'h0, '0, 0, pat(16'h7777));
      tests++; if (r_nrd !== 1 || r_rd_addr !== 16'h1230 || r_rdata !== pat(16'h7777)) begin
         fails++; $display("FAIL t1_not_alloc: got %0d reads addr %h want 1 addr 1230", r_nrd, r_rd_addr); end
   endtask

   task automatic test_hit_swap();
      do_reset();
      do_req(1, 16'h4560, 0, 16'h0, pat(16'h4560), 0, '0);
      tests++; if (r_cyc !== 2 || r_nrd + r_nwr !== 0) begin
         fails++; $display("FAIL t2_write_insert: got cyc %0d pmem %0d want 2 0", r_cyc, r_nrd + r_nwr); end
      do_req(0, 16'h4560, 1, 16'h7890, pat(16'h7890), 1, pat(16'hdead));
      tests++; if (r_cyc !== 2 || r_rdata !== pat(16'h4560) || r_nrd + r_nwr !== 0) begin
         fails++; $display("FAIL t2_swap: got cyc %0d data %h want 2 %h", r_cyc, r_rdata, pat(16'h4560)); end
      do_req(0, 16'h7890, 0, 16'h0, '0, 0, pat(16'hdead));
      tests++; if (r_cyc !== 2 || r_rdata !== pat(16'h7890) || r_nrd !== 0) begin
         fails++; $display("FAIL t2_victim_held: got cyc %0d data %h want 2 %h", r_cyc, r_rdata, pat(16'h7890)); end
      do_req(0, 16'h7890, 0, 16'h0, '0, 0, pat(16'hbeef));
      tests++; if (r_nrd !== 1 || r_rdata !== pat(16'hbeef)) begin
         fails++; $display("FAIL t2_invalidated: got %0d reads data %h want 1 %h", r_nrd, r_rdata, pat(16'hbeef)); end
      do_req(0, 16'h8000, 1, 16'h8000, pat(16'h8008), 0, pat(16'hdead));
      tests++; if (r_cyc !== 2 || r_rdata !== pat(16'h8008) || r_nrd + r_nwr !== 0) begin
         fails++; $display("FAIL t2_alias: got cyc %0d data %h want 2 %h", r_cyc, r_rdata, pat(16'h8008)); end
   endtask

   task automatic test_dirty_writeback();
      do_reset();
      for (int i = 1; i <= 4; i++)
         do_req(1, 16'(i * 16'h1000), 0, 16'h0, pat(16'(i * 16'h1000)), 1, '0);
      do_req(1, 16'h1000, 0, 16'h0, pat(16'h1000), 1, '0);
      tests++; if (r_cyc !== 2 || r_nwr !== 0) begin
         fails++; $display("FAIL t3_touch: got cyc %0d writes %0d want 2 0", r_cyc, r_nwr); end
      do_req(1, 16'h5000, 0, 16'h0, pat(16'h5000), 1, '0);
      tests++; if (r_nwr !== 1 || r_wr_addr !== 16'h2000 || r_wr_data !== pat(16'h2000)) begin
         fails++; $display("FAIL t3_wb: got %0d writes addr %h data %h want 1 2000", r_nwr, r_wr_addr, r_wr_data); end
      tests++; if (r_cyc !== 3) begin
         fails++; $display("FAIL t3_wb_latency: got %0d want 3", r_cyc); end
      do_req(0, 16'h5000, 0, 16'h0, '0, 0, pat(16'hdead));
      tests++; if (r_cyc !== 2 || r_rdata !== pat(16'h5000)) begin
         fails++; $display("FAIL t3_installed: got cyc %0d data %h want 2 %h", r_cyc, r_rdata, pat(16'h5000)); end
      do_req(0, 16'h2000, 0, 16'h0, '0, 0, pat(16'hbeef));
      tests++; if (r_nrd !== 1) begin
         fails++; $display("FAIL t3_evicted: got %0d reads want 1", r_nrd); end
   endtask

   task automatic test_clean_lru();
      do_reset();
      for (int i = 1; i <= 4; i++)
         do_req(1, 16'(i * 16'h1000), 0, 16'h0, pat(16'(i * 16'h1000)), 0, '0);
      do_req(1, 16'h6000, 0, 16'h0, pat(16'h6000), 0, '0);
      tests++; if (r_cyc !== 2 || r_nwr !== 0 || r_nrd !== 0) begin
         fails++; $display("FAIL t4_clean_insert: got cyc %0d wr %0d rd %0d want 2 0 0", r_cyc, r_nwr, r_nrd); end
      do_req(0, 16'h1000, 0, 16'h0, '0, 0, pat(16'hbeef));
      tests++; if (r_nrd !== 1) begin
         fails++; $display("FAIL t4_lru_gone: got %0d reads want 1", r_nrd); end
      do_req(0, 16'h2000, 0, 16'h0, '0, 0, pat(16'hdead));
      tests++; if (r_cyc !== 2 || r_rdata !== pat(16'h2000)) begin
         fails++; $display("FAIL t4_mru_kept: got cyc %0d data %h want 2 %h", r_cyc, r_rdata, pat(16'h2000)); end
   endtask

   task automatic test_reset_mid_fetch();
      bit seen;
      do_reset();
      @(negedge clk);
      bus.l2_read = 1; bus.l2_address = 16'h2340; bus.l2_victim_valid = 0;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.pmem_read) begin seen = 1; break; end
      end
      tests++; if (seen !== 1'b1) begin
         fails++; $display("FAIL t5_fetch_reached: got %b want 1", seen); end
      rst_n = 0;
      #1;
      tests++; if (bus.pmem_read !== 1'b0) begin
         fails++; $display("FAIL t5_read_drop: got %b want 0", bus.pmem_read); end
      bus.l2_read = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.l2_resp) seen = 1;
      end
      tests++; if (seen !== 1'b0) begin
         fails++; $display("FAIL t5_no_resp: got %b want 0", seen); end
      do_req(0, 16'h2340, 0, 16'h0, '0, 0, pat(16'h2340));
      tests++; if (r_cyc !== 3 || r_rdata !== pat(16'h2340) || r_nrd !== 1) begin
         fails++; $display("FAIL t5_recover: got cyc %0d data %h want 3 %h", r_cyc, r_rdata, pat(16'h2340)); end
   endtask

`ifdef VC_STATS_EN
   task automatic test_stats();
      do_reset();
      for (int i = 1; i <= 4; i++)
         do_req(1, 16'(i * 16'h1000), 0, 16'h0, pat(16'(i * 16'h1000)), 1, '0);
      for (int i = 1; i <= 3; i++)
         do_req(0, 16'(i * 16'h1000), 1, 16'(i * 16'h1000 + 16'h100), pat(16'h0101), 0, '0);
      do_req(0, 16'h9000, 0, 16'h0, '0, 0, pat(16'h9000));
      do_req(0, 16'hA000, 1, 16'hA100, pat(16'hA100), 1, pat(16'hA000));
      tests++; if (r_nwr !== 1 || r_wr_addr !== 16'h4000) begin
         fails++; $display("FAIL t6_wb_addr: got %0d writes addr %h want 1 4000", r_nwr, r_wr_addr); end
      tests++; if (hit_count !== 32'd3 || miss_count !== 32'd2 || wb_count !== 32'd1) begin
         fails++; $display("FAIL t6_counts: got %0d/%0d/%0d want 3/2/1", hit_count, miss_count, wb_count); end
   endtask
`endif

   initial begin
      clear_inputs();
      test_reset();
      test_miss_fetch();
      test_hit_swap();
      test_dirty_writeback();
      test_clean_lru();
      test_reset_mid_fetch();
`ifdef VC_STATS_EN
      test_stats();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
